// File: rtl/pc_next_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_if
//  Description : Bundle of signals between the execute/hazard logic and the
//                program-counter stage.
//                master modport : pipeline side (drives redirect/stall/halt
//                                 requests, receives PC and status)
//                slave modport  : pc_next_unit side
//  Signals     : pcsel, br_pc, br_imm, jmp, jmp_index, jr, jr_addr, stall,
//                halt, resume (requests into the PC stage);
//                pc, pc_plus4, flush, halted, redirect_cnt (PC stage results)
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_next_if #(
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 32
);
    // Requests from EX / hazard unit
    logic                  pcsel;
    logic [DATA_BITS-1:0]  br_pc;
    logic [15:0]           br_imm;
    logic                  jmp;
    logic [25:0]           jmp_index;
    logic                  jr;
    logic [DATA_BITS-1:0]  jr_addr;
    logic                  stall;
    logic                  halt;
    logic                  resume;

    // Results from the PC stage
    logic [DATA_BITS-1:0]  pc;
    logic [DATA_BITS-1:0]  pc_plus4;
    logic                  flush;
    logic                  halted;
    logic [CNT_BITS-1:0]   redirect_cnt;

    modport master (
        output pcsel, br_pc, br_imm, jmp, jmp_index, jr, jr_addr,
               stall, halt, resume,
        input  pc, pc_plus4, flush, halted, redirect_cnt
    );

    modport slave (
        input  pcsel, br_pc, br_imm, jmp, jmp_index, jr, jr_addr,
               stall, halt, resume,
        output pc, pc_plus4, flush, halted, redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Program-counter stage. Holds the PC register, selects the
//                next fetch address (PC+4, branch, J/JAL, JR/JALR), raises a
//                one-cycle flush on a taken redirect, implements a RUN/HALTED
//                state machine and counts taken redirects.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - pc_next_if.slave (requests in, pc/status out)
//  Parameters  : DATA_BITS (>= 29), RESET_PC, CNT_BITS
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_unit #(
    parameter int                   DATA_BITS = 32,
    parameter logic [DATA_BITS-1:0] RESET_PC  = 32'h0000_3000,
    parameter int                   CNT_BITS  = 32
) (
    input  wire        clk,
    input  wire        rst_n,
    pc_next_if.slave   bus
);

    localparam logic [DATA_BITS-1:0] c_PC_STEP = DATA_BITS'(4);
    localparam logic [CNT_BITS-1:0]  c_CNT_ONE = CNT_BITS'(1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_BITS-1:0]  r_pc;
    logic                  r_halted;
    logic [CNT_BITS-1:0]   r_cnt;

    logic [DATA_BITS-1:0]  w_br_plus4;
    logic [DATA_BITS-1:0]  w_br_off;
    logic [DATA_BITS-1:0]  w_br_tgt;
    logic [DATA_BITS-1:0]  w_j_tgt;
    logic [DATA_BITS-1:0]  w_tgt;
    logic                  w_redirect;
    logic                  w_flush;

    // Targets are all relative to the instruction sitting in EX, not to the
    // current fetch PC.
    assign w_br_plus4 = bus.br_pc + c_PC_STEP;
    assign w_br_off   = {{(DATA_BITS-18){bus.br_imm[15]}}, bus.br_imm, 2'b00};
    assign w_br_tgt   = w_br_plus4 + w_br_off;
    // J/JAL keeps the region bits of the delay-slot address above bit 27.
    assign w_j_tgt    = {w_br_plus4[DATA_BITS-1:28], bus.jmp_index, 2'b00};

    assign w_redirect = bus.jr | bus.jmp | bus.pcsel;

    // Target priority: jr > jmp > branch.
    always_comb begin
        w_tgt = w_br_tgt;
        if (bus.jr) begin
            w_tgt = bus.jr_addr;
        end else if (bus.jmp) begin
            w_tgt = w_j_tgt;
        end
    end

    // A halt in the same cycle suppresses the redirect; nothing is flushed
    // while reset is asserted even if the request inputs are active.
    assign w_flush = w_redirect & ~bus.halt & (r_state == ST_RUN) & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else if (w_redirect) begin
                        // EX redirect overrides an ID-stage stall.
                        r_pc <= w_tgt;
                    end else if (!bus.stall) begin
                        r_pc <= r_pc + c_PC_STEP;
                    end
                end
                ST_HALTED: begin
                    // PC holds on the resume edge; fetch restarts next edge.
                    if (bus.resume) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase

            if (w_flush) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.pc           = r_pc;
    assign bus.pc_plus4     = r_pc + c_PC_STEP;
    assign bus.flush        = w_flush;
    assign bus.halted       = r_halted;
    assign bus.redirect_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_next_unit
//  Description : Directed self-checking bench for pc_next_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_next_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_next_if #(.DATA_BITS(32), .CNT_BITS(32)) bus ();

    pc_next_unit #(
        .DATA_BITS (32),
        .RESET_PC  (32'h0000_3000),
        .CNT_BITS  (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.pcsel     = 1'b0;
        bus.br_pc     = '0;
        bus.br_imm    = '0;
        bus.jmp       = 1'b0;
        bus.jmp_index = '0;
        bus.jr        = 1'b0;
        bus.jr_addr   = '0;
        bus.stall     = 1'b0;
        bus.halt      = 1'b0;
        bus.resume    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_req();
        // Requests active during reset must not flush or move the PC.
        bus.pcsel = 1'b1;
        bus.stall = 1'b1;
        #12;
        check("rst_pc",     bus.pc,           32'h0000_3000);
        check("rst_halted", {31'b0, bus.halted}, 32'd0);
        check("rst_cnt",    bus.redirect_cnt, 32'd0);
        check("rst_flush",  {31'b0, bus.flush},  32'd0);
        clear_req();
        rst_n = 1'b1;
        #1;

        // 1. Sequential fetch
        check("seq0_pc",    bus.pc,       32'h0000_3000);
        check("seq0_plus4", bus.pc_plus4, 32'h0000_3004);
        step(); check("seq1_pc", bus.pc, 32'h0000_3004);
        step(); check("seq2_pc", bus.pc, 32'h0000_3008);
        step(); check("seq3_pc", bus.pc, 32'h0000_300C);
        check("seq_flush", {31'b0, bus.flush}, 32'd0);
        check("seq_cnt",   bus.redirect_cnt,   32'd0);

        // 2. Backward branch: 0x3014 - 16 = 0x3004
        bus.pcsel = 1'b1; bus.br_pc = 32'h0000_3010; bus.br_imm = 16'hFFFC;
        #1;
        check("br_flush", {31'b0, bus.flush}, 32'd1);
        step(); clear_req(); #1;
        check("br_pc",     bus.pc,           32'h0000_3004);
        check("br_cnt",    bus.redirect_cnt, 32'd1);
        check("br_flush0", {31'b0, bus.flush}, 32'd0);

        // 3. Jump overrides stall: {0x3024[31:28], 0x100, 00} = 0x400
        bus.stall = 1'b1; bus.jmp = 1'b1; bus.jmp_index = 26'h000_0100; bus.br_pc = 32'h0000_3020;
        #1;
        check("j_flush", {31'b0, bus.flush}, 32'd1);
        step(); clear_req(); #1;
        check("j_pc",  bus.pc,           32'h0000_0400);
        check("j_cnt", bus.redirect_cnt, 32'd2);

        // Plain stall holds the PC
        bus.stall = 1'b1;
        #1;
        check("stall_flush", {31'b0, bus.flush}, 32'd0);
        step();
        check("stall_pc", bus.pc, 32'h0000_0400);
        clear_req();

        // 4. jr beats branch, single count
        bus.jr = 1'b1; bus.jr_addr = 32'h0040_0000; bus.pcsel = 1'b1;
        bus.br_pc = 32'h0000_1000; bus.br_imm = 16'h0010;
        #1;
        check("jr_flush", {31'b0, bus.flush}, 32'd1);
        step(); clear_req(); #1;
        check("jr_pc",  bus.pc,           32'h0040_0000);
        check("jr_cnt", bus.redirect_cnt, 32'd3);

        // Branch target wraps: 0xFFFFFFFC + 4 = 0
        bus.pcsel = 1'b1; bus.br_pc = 32'hFFFF_FFF8; bus.br_imm = 16'h0001;
        step(); clear_req(); #1;
        check("wrap_pc",  bus.pc,           32'h0000_0000);
        check("wrap_cnt", bus.redirect_cnt, 32'd4);

        // 5. Halt with a pending branch at 0x3008
        bus.jr = 1'b1; bus.jr_addr = 32'h0000_3008;
        step(); clear_req(); #1;
        check("h_setup_pc", bus.pc, 32'h0000_3008);
        bus.halt = 1'b1; bus.pcsel = 1'b1; bus.br_pc = 32'h0000_5000;
        #1;
        check("h_flush", {31'b0, bus.flush}, 32'd0);
        step(); clear_req(); #1;
        check("h_pc",     bus.pc,                32'h0000_3008);
        check("h_halted", {31'b0, bus.halted},   32'd1);
        check("h_cnt",    bus.redirect_cnt,      32'd5);
        // Redirects ignored while halted
        bus.jr = 1'b1; bus.jr_addr = 32'h0000_1234;
        #1;
        check("hj_flush", {31'b0, bus.flush}, 32'd0);
        step(); clear_req(); #1;
        check("hj_pc",  bus.pc,           32'h0000_3008);
        check("hj_cnt", bus.redirect_cnt, 32'd5);
        // Resume: PC holds on the resume edge, then increments
        bus.resume = 1'b1;
        step(); clear_req(); #1;
        check("res_halted", {31'b0, bus.halted}, 32'd0);
        check("res_pc",     bus.pc,              32'h0000_3008);
        step();
        check("res_pc2",    bus.pc,              32'h0000_300C);
        // Resume while running does nothing
        bus.resume = 1'b1;
        step();
        check("rr_pc",     bus.pc,              32'h0000_3010);
        check("rr_halted", {31'b0, bus.halted}, 32'd0);
        // Halt and resume together in RUN: halt wins
        bus.halt = 1'b1;
        step();
        check("hr_halted", {31'b0, bus.halted}, 32'd1);
        check("hr_pc",     bus.pc,              32'h0000_3010);
        bus.halt = 1'b0;          // resume still high -> leaves HALTED
        step(); clear_req(); #1;
        check("hr_resume", {31'b0, bus.halted}, 32'd0);

        // 6. Async reset while halted at 0x3040
        bus.jr = 1'b1; bus.jr_addr = 32'h0000_3040;
        step(); clear_req(); #1;
        bus.halt = 1'b1;
        step(); clear_req(); #1;
        check("ar_pre_pc",     bus.pc,              32'h0000_3040);
        check("ar_pre_halted", {31'b0, bus.halted}, 32'd1);
        check("ar_pre_cnt",    bus.redirect_cnt,    32'd6);
        bus.stall = 1'b1;
        #1;
        rst_n = 1'b0;             // mid-cycle, no clock edge involved
        #1;
        check("ar_pc",     bus.pc,              32'h0000_3000);
        check("ar_halted", {31'b0, bus.halted}, 32'd0);
        check("ar_cnt",    bus.redirect_cnt,    32'd0);
        clear_req();
        #1;
        rst_n = 1'b1;
        step();
        check("ar_run_pc", bus.pc, 32'h0000_3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
